// File: rtl/segasys1_sndcmd_fifo.sv
// Main-to-sound command mailbox: edge-strobed push/pop queue with registered FWFT head, flags and IRQ.
// Events take effect at the edge ending their cycle; a full queue either drops or overwrites the oldest entry.
module segasys1_sndcmd_fifo #(
  parameter int              DW        = 8,
  parameter int              AW        = 3,
  parameter int              OVWR      = 0,
  parameter int              IRQ_MODE  = 0,
  parameter int              IRQ_LEN   = 16,
  parameter logic [DW-1:0]   EMPTY_VAL = DW'(8'hFF)
) (
  input  logic          CLK48M,
  input  logic          RESET,
  input  logic          WR_STB,
  input  logic [DW-1:0] WR_DATA,
  input  logic          RD_STB,
  output logic [DW-1:0] RD_DATA,
  output logic          IRQ,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  input  logic          CLR_OVF
);

  localparam int              DEPTH      = 1 << AW;
  localparam logic [AW:0]     FULL_CNT   = {1'b1, {AW{1'b0}}};
  localparam bit              OVWR_EN    = (OVWR != 0);
  localparam bit              IRQ_PULSE  = (IRQ_MODE != 0);
  localparam int              ICW        = (IRQ_LEN < 2) ? 1 : $clog2(IRQ_LEN + 1);
  localparam logic [ICW-1:0]  IRQ_RELOAD = ICW'(IRQ_LEN);

  logic [DW-1:0]  r_mem [0:DEPTH-1];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_wr_q;
  logic           r_rd_q;
  logic           r_empty;
  logic           r_full;
  logic           r_ovf;
  logic           r_irq;
  logic [DW-1:0]  r_rd_data;
  logic [ICW-1:0] r_irq_cnt;

  logic           w_push;
  logic           w_pop;
  logic           w_do_pop;
  logic           w_ovf_set;
  logic           w_wr_en;
  logic           w_rd_adv;
  logic [AW-1:0]  w_wptr_nxt;
  logic [AW-1:0]  w_rptr_nxt;
  logic [AW:0]    w_count_nxt;
  logic [DW-1:0]  w_head_nxt;
  logic [ICW-1:0] w_irq_cnt_nxt;

  assign w_push    = WR_STB & ~r_wr_q;
  assign w_pop     = RD_STB & ~r_rd_q;
  assign w_do_pop  = w_pop & ~r_empty;
  // A push into a full queue only overflows when no pop frees a slot in the same cycle.
  assign w_ovf_set = w_push & r_full & ~w_do_pop;
  assign w_wr_en   = w_push & (~r_full | w_do_pop | OVWR_EN);
  assign w_rd_adv  = w_do_pop | (w_ovf_set & OVWR_EN);

  always_comb begin
    w_wptr_nxt    = r_wptr;
    w_rptr_nxt    = r_rptr;
    w_count_nxt   = r_count;
    w_head_nxt    = EMPTY_VAL;
    w_irq_cnt_nxt = r_irq_cnt;
    if (w_wr_en) w_wptr_nxt = r_wptr + 1'b1;
    if (w_rd_adv) w_rptr_nxt = r_rptr + 1'b1;
    if (w_wr_en && !w_rd_adv) w_count_nxt = r_count + 1'b1;
    else if (!w_wr_en && w_rd_adv) w_count_nxt = r_count - 1'b1;
    // The new head may be the word being written this very cycle, which storage does not hold yet.
    if (w_count_nxt != '0) begin
      if (w_wr_en && (w_rptr_nxt == r_wptr)) w_head_nxt = WR_DATA;
      else w_head_nxt = r_mem[w_rptr_nxt];
    end
    if (w_wr_en) w_irq_cnt_nxt = IRQ_RELOAD;
    else if (r_irq_cnt != '0) w_irq_cnt_nxt = r_irq_cnt - 1'b1;
  end

  always_ff @(posedge CLK48M) begin
    if (w_wr_en) r_mem[r_wptr] <= WR_DATA;
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wr_q    <= 1'b0;
      r_rd_q    <= 1'b0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
      r_rd_data <= EMPTY_VAL;
      r_irq_cnt <= '0;
    end else begin
      r_wr_q    <= WR_STB;
      r_rd_q    <= RD_STB;
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_count   <= w_count_nxt;
      r_empty   <= (w_count_nxt == '0);
      r_full    <= (w_count_nxt == FULL_CNT);
      r_rd_data <= w_head_nxt;
      r_irq_cnt <= w_irq_cnt_nxt;
      r_irq     <= IRQ_PULSE ? (w_irq_cnt_nxt != '0) : (w_count_nxt != '0);
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (CLR_OVF) r_ovf <= 1'b0;
    end
  end

  assign RD_DATA = r_rd_data;
  assign IRQ     = r_irq;
  assign EMPTY   = r_empty;
  assign FULL    = r_full;
  assign COUNT   = r_count;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_segasys1_sndcmd_fifo.sv
// Bench: drop-policy, overwrite-policy and pulse-IRQ mailboxes driven by one shared stimulus stream.
module tb_segasys1_sndcmd_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_stb, rd_stb, clr_ovf;
  logic [7:0] wr_data;

  logic [7:0] rd0, rd1, rd2;
  logic       irq0, irq1, irq2, emp0, emp1, emp2, full0, full1, full2, ovf0, ovf1, ovf2;
  logic [3:0] cnt0, cnt1, cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [3:0] cnt;
    logic [7:0] rdd;
    logic       emp;
    logic       irq;
  } vec_t;

  vec_t vt[16];

  always #5 clk = ~clk;

  segasys1_sndcmd_fifo #(.OVWR(0), .IRQ_MODE(0)) dut0 (
    .CLK48M(clk), .RESET(rst), .WR_STB(wr_stb), .WR_DATA(wr_data), .RD_STB(rd_stb),
    .RD_DATA(rd0), .IRQ(irq0), .EMPTY(emp0), .FULL(full0), .COUNT(cnt0), .OVF(ovf0), .CLR_OVF(clr_ovf));
  segasys1_sndcmd_fifo #(.OVWR(1), .IRQ_MODE(0)) dut1 (
    .CLK48M(clk), .RESET(rst), .WR_STB(wr_stb), .WR_DATA(wr_data), .RD_STB(rd_stb),
    .RD_DATA(rd1), .IRQ(irq1), .EMPTY(emp1), .FULL(full1), .COUNT(cnt1), .OVF(ovf1), .CLR_OVF(clr_ovf));
  segasys1_sndcmd_fifo #(.OVWR(0), .IRQ_MODE(1), .IRQ_LEN(16)) dut2 (
    .CLK48M(clk), .RESET(rst), .WR_STB(wr_stb), .WR_DATA(wr_data), .RD_STB(rd_stb),
    .RD_DATA(rd2), .IRQ(irq2), .EMPTY(emp2), .FULL(full2), .COUNT(cnt2), .OVF(ovf2), .CLR_OVF(clr_ovf));

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                              input logic [3:0] cnt, input logic [7:0] rdd,
                              input logic emp, input logic irq);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = cnt; v.rdd = rdd; v.emp = emp; v.irq = irq;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_stb = w; wr_data = d; rd_stb = r; clr_ovf = c;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst count0", 32'(cnt0), 32'd0);
    check("rst empty0", 32'(emp0), 32'd1);
    check("rst ovf0",   32'(ovf0), 32'd0);
    check("rst irq0",   32'(irq0), 32'd0);
    check("rst irq2",   32'(irq2), 32'd0);
    check("rst rd0",    32'(rd0),  32'hFF);
    #1 rst = 1'b0;
    sb0.delete();
    sb1.delete();
    tick();
  endtask

  task automatic do_push(input logic [7:0] d, input logic c);
    drive(1'b1, d, 1'b0, c);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    if (sb0.size() < 8) sb0.push_back(d);
    if (sb1.size() == 8) void'(sb1.pop_front());
    sb1.push_back(d);
  endtask

  task automatic do_pop_check(input string nm);
    logic [7:0] e0, e1;
    e0 = (sb0.size() > 0) ? sb0[0] : 8'hFF;
    e1 = (sb1.size() > 0) ? sb1[0] : 8'hFF;
    check({nm, " rd0"}, 32'(rd0), 32'(e0));
    check({nm, " rd1"}, 32'(rd1), 32'(e1));
    check({nm, " rd2"}, 32'(rd2), 32'(e0));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    if (sb0.size() > 0) void'(sb0.pop_front());
    if (sb1.size() > 0) void'(sb1.pop_front());
  endtask

  initial begin
    vt[0]  = mk(1'b1, 8'h12, 1'b0, 4'd1, 8'h12, 1'b0, 1'b1);
    vt[1]  = mk(1'b0, 8'h00, 1'b0, 4'd1, 8'h12, 1'b0, 1'b1);
    vt[2]  = mk(1'b0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[3]  = mk(1'b0, 8'h00, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 8'hA0, 1'b0, 4'd1, 8'hA0, 1'b0, 1'b1);
    vt[5]  = mk(1'b0, 8'h00, 1'b0, 4'd1, 8'hA0, 1'b0, 1'b1);
    vt[6]  = mk(1'b1, 8'hB0, 1'b1, 4'd1, 8'hB0, 1'b0, 1'b1);
    vt[7]  = mk(1'b0, 8'h00, 1'b0, 4'd1, 8'hB0, 1'b0, 1'b1);
    vt[8]  = mk(1'b0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[9]  = mk(1'b0, 8'h00, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[10] = mk(1'b1, 8'hB0, 1'b1, 4'd1, 8'hB0, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 8'h00, 1'b0, 4'd1, 8'hB0, 1'b0, 1'b1);
    vt[12] = mk(1'b0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[13] = mk(1'b0, 8'h00, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[14] = mk(1'b0, 8'h00, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
    vt[15] = mk(1'b0, 8'h00, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b0);

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #22 rst = 1'b0;
    check("init count0", 32'(cnt0),  32'd0);
    check("init empty0", 32'(emp0),  32'd1);
    check("init full0",  32'(full0), 32'd0);
    check("init rd0",    32'(rd0),   32'hFF);
    check("init irq0",   32'(irq0),  32'd0);
    check("init ovf0",   32'(ovf0),  32'd0);
    check("init irq2",   32'(irq2),  32'd0);
    tick();

    // Single push/pop, same-cycle push+pop on one-entry and empty queues, pop on empty.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].wr, vt[i].wd, vt[i].rd, 1'b0);
      tick();
      check($sformatf("vec%0d count0", i), 32'(cnt0),  32'(vt[i].cnt));
      check($sformatf("vec%0d rd0", i),    32'(rd0),   32'(vt[i].rdd));
      check($sformatf("vec%0d empty0", i), 32'(emp0),  32'(vt[i].emp));
      check($sformatf("vec%0d irq0", i),   32'(irq0),  32'(vt[i].irq));
      check($sformatf("vec%0d full0", i),  32'(full0), 32'd0);
      check($sformatf("vec%0d ovf0", i),   32'(ovf0),  32'd0);
      check($sformatf("vec%0d count1", i), 32'(cnt1),  32'(vt[i].cnt));
      check($sformatf("vec%0d rd1", i),    32'(rd1),   32'(vt[i].rdd));
      check($sformatf("vec%0d count2", i), 32'(cnt2),  32'(vt[i].cnt));
    end

    // Held strobe counts once.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (20) tick();
    check("hold count0", 32'(cnt0), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("hold count0 after", 32'(cnt0), 32'd1);
    check("hold rd0", 32'(rd0), 32'h55);
    sb0.push_back(8'h55);
    sb1.push_back(8'h55);
    do_pop_check("hold pop");
    check("hold empty0", 32'(emp0), 32'd1);

    // Fill, overflow, drain.
    for (int i = 1; i <= 8; i++) do_push(8'(i), 1'b0);
    check("fill full0",  32'(full0), 32'd1);
    check("fill count0", 32'(cnt0),  32'd8);
    check("fill full1",  32'(full1), 32'd1);
    check("fill ovf0",   32'(ovf0),  32'd0);
    do_push(8'h09, 1'b0);
    check("ovf ovf0",   32'(ovf0), 32'd1);
    check("ovf ovf1",   32'(ovf1), 32'd1);
    check("ovf count0", 32'(cnt0), 32'd8);
    check("ovf count1", 32'(cnt1), 32'd8);
    for (int i = 0; i < 8; i++) do_pop_check($sformatf("drain%0d", i));
    check("drain empty0", 32'(emp0), 32'd1);
    check("drain empty1", 32'(emp1), 32'd1);

    // Clear, full push+pop without overflow, overflow coinciding with clear.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr ovf0", 32'(ovf0), 32'd0);
    check("clr ovf1", 32'(ovf1), 32'd0);
    for (int i = 0; i < 8; i++) do_push(8'h11 + 8'(i), 1'b0);
    drive(1'b1, 8'h19, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    void'(sb0.pop_front()); sb0.push_back(8'h19);
    void'(sb1.pop_front()); sb1.push_back(8'h19);
    check("fullpp count0", 32'(cnt0), 32'd8);
    check("fullpp ovf0",   32'(ovf0), 32'd0);
    check("fullpp ovf1",   32'(ovf1), 32'd0);
    check("fullpp rd0",    32'(rd0),  32'h12);
    do_push(8'h1A, 1'b1);
    check("setclr ovf0", 32'(ovf0), 32'd1);
    check("setclr ovf1", 32'(ovf1), 32'd1);
    for (int i = 0; i < 5; i++) do_pop_check($sformatf("part%0d", i));
    check("part count0", 32'(cnt0), 32'd3);

    // Reset with three entries queued and OVF set.
    pulse_reset();
    check("post rst count1", 32'(cnt1), 32'd0);
    check("post rst empty2", 32'(emp2), 32'd1);

    // Pulse IRQ: single push, pop does not cut the pulse.
    for (int c = 0; c <= 20; c++) begin
      check($sformatf("irqA c%0d irq2", c), 32'(irq2), 32'((c >= 1) && (c <= 16)));
      check($sformatf("irqA c%0d irq0", c), 32'(irq0), 32'((c >= 1) && (c <= 5)));
      drive(c == 0, 8'h77, c == 5, 1'b0);
      tick();
    end

    // Pulse IRQ retrigger.
    pulse_reset();
    for (int c = 0; c <= 30; c++) begin
      check($sformatf("irqB c%0d irq2", c), 32'(irq2), 32'((c >= 1) && (c <= 26)));
      check($sformatf("irqB c%0d irq0", c), 32'(irq0), 32'(c >= 1));
      drive((c == 0) || (c == 10), 8'(c), 1'b0, 1'b0);
      tick();
    end
    check("irqB count2", 32'(cnt2), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/segasys1_sndcmd_fifo.md
Name: segasys1_sndcmd_fifo

Overview:
Parametrised main-to-sound command mailbox. It replaces the single-byte SNDNO latch and one-cycle SNDRQ pulse with a queue of configurable depth and data width, edge-detected strobes, a selectable overflow policy, and a configurable sound-CPU interrupt style. It sits between the main CPU I/O write decode (ports 0x14/0x18) and the sound CPU read/IRQ logic. The whole block runs on CLK48M.

Parameters:
DW, 8, command data width in bits
AW, 3, log2 of queue depth (DEPTH = 2^AW)
OVWR, 0, full policy: 0 = drop the new command, 1 = overwrite the oldest entry
IRQ_MODE, 0, 0 = IRQ is a level while the queue is non-empty; 1 = IRQ pulses on each accepted push
IRQ_LEN, 16, IRQ pulse length in CLK48M cycles (used only when IRQ_MODE=1; must be at least 1)
EMPTY_VAL, 8'hFF, value driven on RD_DATA when the queue is empty (DW wide)

Ports:
CLK48M  in  1  system clock; all state on its rising edge
RESET  in  1  asynchronous, active-high reset
WR_STB  in  1  main-side write request, level; acts on its rising edge only
WR_DATA  in  DW  command byte, sampled in the cycle the WR_STB edge is detected
RD_STB  in  1  sound-side read/acknowledge, level; acts on its rising edge only
RD_DATA  out  DW  head entry (first-word fall-through), or EMPTY_VAL when empty
IRQ  out  1  interrupt request to the sound CPU
EMPTY  out  1  queue empty
FULL  out  1  queue full
COUNT  out  AW+1  number of stored entries, range 0..DEPTH
OVF  out  1  sticky overflow flag
CLR_OVF  in  1  synchronous clear of OVF

Behaviour:
- Reset (asynchronous):
  - Pointers, COUNT, OVF, IRQ and the edge-detect registers go to 0.
  - EMPTY=1, FULL=0, RD_DATA=EMPTY_VAL.
  - Storage contents are don't-care.
  - A reset asserted mid-operation discards all queued commands.
- Edge detection:
  - push = WR_STB & ~wr_q; pop = RD_STB & ~rd_q; wr_q and rd_q are registered every cycle.
  - A strobe held high for many cycles counts as one event.
- Latency: an event detected in cycle k updates COUNT, flags and RD_DATA at the clock edge ending cycle k; the new values are visible in cycle k+1.
- RD_DATA, EMPTY and FULL are registered and always consistent with COUNT.
- Push, not full: write WR_DATA at wptr, wptr+1 (mod DEPTH), COUNT+1.
- Push when full:
  - OVWR=0: data dropped, OVF set, pointers unchanged.
  - OVWR=1: write at wptr, advance both wptr and rptr, COUNT unchanged, OVF set.
- Pop:
  - Not empty: rptr+1, COUNT-1.
  - Empty: ignored, no flag set.
- Simultaneous push and pop:
  - Not empty and not full: both are performed, COUNT unchanged.
  - Full: both are performed, COUNT unchanged, OVF not set.
  - Empty: push only.
- Pointer wrap: AW-bit modular pointers; FULL is COUNT==DEPTH.
- OVF:
  - Set by a dropped or overwritten push.
  - CLR_OVF clears it.
  - If set and clear occur in the same cycle, set wins.
- IRQ:
  - IRQ_MODE=0: IRQ = ~EMPTY (registered).
  - IRQ_MODE=1: each accepted push, including an overwriting push, reloads a down-counter with IRQ_LEN. IRQ=1 while the counter is non-zero, so a push during a pulse retriggers it. The pop side does not affect IRQ.

Test Plan:
- Reset, then push 0x12 (WR_STB edge in cycle k) -> cycle k+1: RD_DATA=0x12, COUNT=1, EMPTY=0, IRQ=1 (IRQ_MODE=0); pop -> RD_DATA=0xFF, EMPTY=1, IRQ=0.
- AW=3: push 0x01..0x08 -> FULL=1, COUNT=8. Push 0x09: with OVWR=0, OVF=1 and the pops return 01..08; with OVWR=1, OVF=1 and the pops return 02..09.
- Hold WR_STB high for 20 cycles with WR_DATA=0x55 -> exactly one entry, COUNT=1.
- Queue holds {0xA0}; push 0xB0 and pop in the same cycle -> COUNT=1, RD_DATA=0xB0. Repeat on an empty queue -> COUNT=1, RD_DATA=0xB0.
- IRQ_MODE=1, IRQ_LEN=16: push at cycle 0 -> IRQ high for cycles 1..16. Second push at cycle 10 -> IRQ stays high through cycle 26.
- Three entries queued, RESET pulsed mid-stream -> COUNT=0, EMPTY=1, OVF=0, IRQ=0 immediately. CLR_OVF coinciding with an overflowing push -> OVF=1.
